frame_config_ctrl: RTL and testbench
====================================

Name: frame_config_ctrl

Overview:
- Sequences the fabric's latch-based configuration memory.
- Accepts a stream of 32-bit configuration words over a valid/ready interface and hunts for a sync word.
- Decodes per-frame headers, assembles one full-column frame (one word per tile row) and drives it on FrameData.
- Pulses exactly one FrameStrobe line (frame within column) for a programmable width, so the target column's frame latches capture the data.

Parameters:
- FrameBitsPerRow, 32, bits per tile row per frame; equals stream word width.
- NumRows, 4, tile rows per column; data words per frame.
- MaxFramesPerCol, 20, frames per column.
- NumColumns, 4, fabric columns.
- StrobeWidth, 2, cycles FrameStrobe stays high (at least 1).
- SyncWord, 32'hFAB0FAB1, stream start marker.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous active-high reset.
- WordData  in  32  configuration stream word.
- WordValid  in  1  WordData valid.
- WordReady  out  1  controller accepts word; transfer occurs when WordValid && WordReady at a CLK edge.
- FrameData  out  FrameBitsPerRow*NumRows  assembled frame; row k at [k*FrameBitsPerRow +: FrameBitsPerRow].
- FrameStrobe  out  MaxFramesPerCol*NumColumns  one-hot strobe; bit index = col*MaxFramesPerCol + frame.
- Busy  out  1  high in any state other than SYNC_WAIT and DONE.
- ConfigDone  out  1  high while in DONE.
- ConfigError  out  1  sticky bad-header flag.

Behaviour:
- Reset: one clock; RESET is synchronous and active-high. On reset, state=SYNC_WAIT, FrameData=0, FrameStrobe=0, ConfigDone=0, ConfigError=0, Busy=0, row counter=0, strobe counter=0.
- RESET has priority over every event. A reset during STROBE drops FrameStrobe at that edge, and the partial frame is discarded.
- All outputs are registered.
- WordReady=1 in SYNC_WAIT, HEADER, DATA and DONE; WordReady=0 in SETUP, STROBE and HOLD.
- Header word fields: [7:0] frame index; [15:8] column index; [31] END flag; all other bits are ignored.
- SYNC_WAIT: accepted word == SyncWord -> HEADER and ConfigError cleared. Any other word is dropped.
- HEADER, on an accepted word:
  - END=1 -> DONE.
  - Otherwise, frame >= MaxFramesPerCol or column >= NumColumns -> ConfigError=1, go to SYNC_WAIT.
  - Otherwise latch frame and column, row counter=0, go to DATA.
- DATA: each accepted word is written into FrameData row[row counter], then the counter increments. The word accepted with counter==NumRows-1 moves the state to SETUP. Rows not yet written keep their previous contents.
- SETUP: one cycle; FrameData stable, strobe low.
- STROBE: FrameStrobe[col*MaxFramesPerCol+frame]=1 for exactly StrobeWidth cycles, then HOLD.
- HOLD: one cycle; strobe low, FrameData held, then HEADER.
- Timing: last data word accepted at edge t gives:
  - SETUP at t+1.
  - Strobe high from t+2 through t+1+StrobeWidth.
  - HOLD at t+2+StrobeWidth.
  - WordReady=1 again at t+3+StrobeWidth.
- DONE: ConfigDone=1, Busy=0. Accepted SyncWord -> HEADER (ConfigDone=0, ConfigError cleared). Other words are dropped.
- FrameData changes only on DATA transfers, so it never changes while any strobe is high.
- WordValid low in any state: state and counters hold.

Decomposition:
- Shared package frame_config_pkg:
  - State enumeration.
  - Header field bit positions (FRAME_LSB=0, COL_LSB=8, END_BIT=31).
  - Default sync word constant.
- Sub-module frame_strobe_decoder: combinational (frame, col, enable) -> one-hot FrameStrobe vector. Its output is registered in the parent.

Test Plan:
- Defaults. Stream SyncWord, header 0x0000_0203 (col 2, frame 3), data 0x11111111/0x22222222/0x33333333/0x44444444 -> FrameData=0x44444444_33333333_22222222_11111111; FrameStrobe bit 43 high for exactly 2 cycles, starting 2 cycles after the last data handshake; WordReady low for 4 cycles.
- Garbage 0xDEADBEEF before SyncWord -> dropped, state stays SYNC_WAIT, Busy=0; then a normal frame completes.
- Header 0x0000_0014 (frame 20) -> ConfigError=1, no strobe; subsequent data words are dropped until SyncWord, which clears ConfigError.
- Header 0x8000_0000 after one good frame -> ConfigDone=1, Busy=0; a new SyncWord returns to HEADER with ConfigDone=0.
- RESET asserted on the first strobe cycle -> FrameStrobe=0 and FrameData=0 at the next edge, state SYNC_WAIT, WordReady=1.
- WordValid toggled randomly during DATA -> only handshaked words load, row order preserved, strobe timing measured from the final handshake.

Source files
------------

// File: rtl/frame_config_pkg.sv
// Shared types and constants for the frame configuration controller.
package frame_config_pkg;

    typedef enum logic [2:0] {
        StSyncWait,
        StHeader,
        StData,
        StSetup,
        StStrobe,
        StHold,
        StDone
    } state_e;

    localparam int unsigned FRAME_LSB = 0;
    localparam int unsigned COL_LSB   = 8;
    localparam int unsigned END_BIT   = 31;

    localparam logic [31:0] DEFAULT_SYNC_WORD = 32'hFAB0_FAB1;

endpackage

// File: rtl/frame_strobe_decoder.sv
// Combinational decode of (column, frame) into a one-hot frame strobe vector.
module frame_strobe_decoder #(
    parameter int unsigned MaxFramesPerCol = 20,
    parameter int unsigned NumColumns      = 4
) (
    input  logic [7:0]                            frame_i,
    input  logic [7:0]                            col_i,
    input  logic                                  en_i,
    output logic [MaxFramesPerCol*NumColumns-1:0] strobe_o
);

    int unsigned idx;

    always_comb begin
        idx = 32'(col_i) * MaxFramesPerCol + 32'(frame_i);
        strobe_o = '0;
        for (int unsigned i = 0; i < MaxFramesPerCol * NumColumns; i++) begin
            strobe_o[i] = en_i && (idx == i);
        end
    end

endmodule

// File: rtl/frame_config_ctrl.sv
// Configuration stream sequencer: sync hunt, header decode, frame assembly and strobe pulse.
module frame_config_ctrl
    import frame_config_pkg::*;
#(
    parameter int unsigned FrameBitsPerRow = 32,
    parameter int unsigned NumRows         = 4,
    parameter int unsigned MaxFramesPerCol = 20,
    parameter int unsigned NumColumns      = 4,
    parameter int unsigned StrobeWidth     = 2,
    parameter logic [31:0] SyncWord        = DEFAULT_SYNC_WORD
) (
    input  logic                                  CLK,
    input  logic                                  RESET,
    input  logic [31:0]                           WordData,
    input  logic                                  WordValid,
    output logic                                  WordReady,
    output logic [FrameBitsPerRow*NumRows-1:0]    FrameData,
    output logic [MaxFramesPerCol*NumColumns-1:0] FrameStrobe,
    output logic                                  Busy,
    output logic                                  ConfigDone,
    output logic                                  ConfigError
);

    localparam int unsigned RowW = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam int unsigned CntW = (StrobeWidth > 1) ? $clog2(StrobeWidth) : 1;

    state_e                                state_q, state_d;
    logic [7:0]                            frame_q, frame_d;
    logic [7:0]                            col_q, col_d;
    logic [RowW-1:0]                       row_q, row_d;
    logic [CntW-1:0]                       cnt_q, cnt_d;
    logic [FrameBitsPerRow*NumRows-1:0]    data_q, data_d;
    logic                                  err_q, err_d;
    logic                                  ready_q, busy_q, done_q;
    logic [MaxFramesPerCol*NumColumns-1:0] strobe_q, strobe_d;
    logic                                  xfer;
    logic [7:0]                            hdr_frame, hdr_col;

    assign xfer      = WordValid && ready_q;
    assign hdr_frame = WordData[FRAME_LSB +: 8];
    assign hdr_col   = WordData[COL_LSB +: 8];

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        col_d   = col_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        unique case (state_q)
            StSyncWait, StDone: begin
                if (xfer && WordData == SyncWord) begin
                    state_d = StHeader;
                    err_d   = 1'b0;
                end
            end
            StHeader: begin
                if (xfer) begin
                    if (WordData[END_BIT]) begin
                        state_d = StDone;
                    end else if (32'(hdr_frame) >= MaxFramesPerCol ||
                                 32'(hdr_col) >= NumColumns) begin
                        err_d   = 1'b1;
                        state_d = StSyncWait;
                    end else begin
                        frame_d = hdr_frame;
                        col_d   = hdr_col;
                        row_d   = '0;
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (xfer) begin
                    data_d[32'(row_q)*FrameBitsPerRow +: FrameBitsPerRow] =
                        WordData[FrameBitsPerRow-1:0];
                    if (row_q == RowW'(NumRows - 1)) begin
                        row_d   = '0;
                        state_d = StSetup;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            StSetup: begin
                cnt_d   = '0;
                state_d = StStrobe;
            end
            StStrobe: begin
                if (cnt_q == CntW'(StrobeWidth - 1)) begin
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHold:  state_d = StHeader;
            default: state_d = StSyncWait;
        endcase
    end

    // Strobe is decoded from next-state so the registered pulse aligns with StStrobe.
    frame_strobe_decoder #(
        .MaxFramesPerCol(MaxFramesPerCol),
        .NumColumns     (NumColumns)
    ) u_decoder (
        .frame_i (frame_d),
        .col_i   (col_d),
        .en_i    (state_d == StStrobe),
        .strobe_o(strobe_d)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= StSyncWait;
            frame_q  <= '0;
            col_q    <= '0;
            row_q    <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            strobe_q <= '0;
        end else begin
            state_q  <= state_d;
            frame_q  <= frame_d;
            col_q    <= col_d;
            row_q    <= row_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            err_q    <= err_d;
            ready_q  <= (state_d == StSyncWait) || (state_d == StHeader) ||
                        (state_d == StData) || (state_d == StDone);
            busy_q   <= !((state_d == StSyncWait) || (state_d == StDone));
            done_q   <= (state_d == StDone);
            strobe_q <= strobe_d;
        end
    end

    assign WordReady   = ready_q;
    assign FrameData   = data_q;
    assign FrameStrobe = strobe_q;
    assign Busy        = busy_q;
    assign ConfigDone  = done_q;
    assign ConfigError = err_q;

endmodule

// File: tb/tb_frame_config_ctrl.sv
// Directed self-checking bench for frame_config_ctrl with default parameters.
module tb_frame_config_ctrl;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [31:0]  WordData;
    logic         WordValid;
    logic         WordReady;
    logic [127:0] FrameData;
    logic [79:0]  FrameStrobe;
    logic         Busy;
    logic         ConfigDone;
    logic         ConfigError;

    int vectors = 0;
    int errs    = 0;

    localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

    frame_config_ctrl dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .WordData   (WordData),
        .WordValid  (WordValid),
        .WordReady  (WordReady),
        .FrameData  (FrameData),
        .FrameStrobe(FrameStrobe),
        .Busy       (Busy),
        .ConfigDone (ConfigDone),
        .ConfigError(ConfigError)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Returns 1ns after the handshake edge.
    task automatic send(input logic [31:0] w);
        int n = 0;
        WordData  = w;
        WordValid = 1'b1;
        while (!WordReady && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            vectors++;
            errs++;
            $display("FAIL send_timeout: observed WordReady=0 expected 1 within 50 cycles");
        end
        tick();
        WordValid = 1'b0;
    endtask

    // Call right after the last data handshake of a frame.
    task automatic check_frame(input string tag, input logic [127:0] exp_data, input int idx);
        logic [79:0] s;
        s = '0;
        s[idx] = 1'b1;
        check({tag, "_data"}, FrameData, exp_data);
        check({tag, "_setup_strobe"}, FrameStrobe, 128'd0);
        check({tag, "_setup_ready"}, WordReady, 1'b0);
        tick();
        check({tag, "_strobe1"}, FrameStrobe, s);
        check({tag, "_strobe1_ready"}, WordReady, 1'b0);
        tick();
        check({tag, "_strobe2"}, FrameStrobe, s);
        check({tag, "_strobe2_data"}, FrameData, exp_data);
        tick();
        check({tag, "_hold_strobe"}, FrameStrobe, 128'd0);
        check({tag, "_hold_ready"}, WordReady, 1'b0);
        tick();
        check({tag, "_header_ready"}, WordReady, 1'b1);
        check({tag, "_header_busy"}, Busy, 1'b1);
    endtask

    initial begin
        logic [31:0] rows [4];
        RESET     = 1'b1;
        WordValid = 1'b0;
        WordData  = '0;
        tick();
        tick();
        RESET = 1'b0;
        check("rst_ready", WordReady, 1'b1);
        check("rst_busy", Busy, 1'b0);
        check("rst_done", ConfigDone, 1'b0);
        check("rst_err", ConfigError, 1'b0);
        check("rst_data", FrameData, 128'd0);
        check("rst_strobe", FrameStrobe, 128'd0);

        // Garbage before sync is dropped.
        send(32'hDEAD_BEEF);
        check("garbage_busy", Busy, 1'b0);
        check("garbage_ready", WordReady, 1'b1);

        send(SYNC);
        check("sync_busy", Busy, 1'b1);
        send(32'h0000_0203);
        send(32'h1111_1111);
        send(32'h2222_2222);
        send(32'h3333_3333);
        send(32'h4444_4444);
        check_frame("f1", 128'h44444444_33333333_22222222_11111111, 43);

        // Frame index out of range.
        send(32'h0000_0014);
        check("bad_frame_err", ConfigError, 1'b1);
        check("bad_frame_busy", Busy, 1'b0);
        send(32'h1111_1111);
        check("bad_drop_err", ConfigError, 1'b1);
        check("bad_drop_strobe", FrameStrobe, 128'd0);
        check("bad_drop_data", FrameData, 128'h44444444_33333333_22222222_11111111);
        send(SYNC);
        check("resync_err", ConfigError, 1'b0);
        check("resync_busy", Busy, 1'b1);

        // Column index out of range.
        send(32'h0000_0400);
        check("bad_col_err", ConfigError, 1'b1);
        send(SYNC);
        check("resync2_err", ConfigError, 1'b0);

        // Col 1 frame 5 with idle gaps between handshakes.
        rows[0] = 32'hAAAA_0001;
        rows[1] = 32'hBBBB_0002;
        rows[2] = 32'hCCCC_0003;
        rows[3] = 32'hDDDD_0004;
        send(32'h0000_0105);
        for (int i = 0; i < 4; i++) begin
            WordValid = 1'b0;
            WordData  = $urandom;
            repeat ($urandom_range(0, 3)) tick();
            check("gap_strobe", FrameStrobe, 128'd0);
            send(rows[i]);
        end
        check_frame("f2", {rows[3], rows[2], rows[1], rows[0]}, 25);

        // End marker.
        send(32'h8000_0000);
        check("end_done", ConfigDone, 1'b1);
        check("end_busy", Busy, 1'b0);
        check("end_ready", WordReady, 1'b1);
        send(32'h1234_5678);
        check("done_drop", ConfigDone, 1'b1);
        send(SYNC);
        check("done_sync_done", ConfigDone, 1'b0);
        check("done_sync_busy", Busy, 1'b1);

        // Reset on the first strobe cycle.
        send(32'h0000_0000);
        send(32'h0101_0101);
        send(32'h0202_0202);
        send(32'h0303_0303);
        send(32'h0404_0404);
        tick();
        check("rs_strobe_on", FrameStrobe, 128'd1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check("rs_strobe", FrameStrobe, 128'd0);
        check("rs_data", FrameData, 128'd0);
        check("rs_ready", WordReady, 1'b1);
        check("rs_busy", Busy, 1'b0);
        tick();
        check("rs_stay_busy", Busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
